muldiv_issue_ctrl: RTL

- Pipeline-side initiator for the multi-cycle M-extension mul/div unit.
- Accepts one mul/div request from the execute stage and drives the unit's start pulse, alucode and operands.
- Waits for the unit's done, captures the result and presents it to writeback with a valid/ready handshake.
- Provides a stall indication, flush handling and a watchdog timeout.

---
 rtl/muldiv_issue_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - issue/response controller for the multi-cycle mul/div unit
// Optional reuse of the last completed result is enabled by defining MULDIV_RESULT_REUSE_EN.
module muldiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        busy,
    output logic        timeout_err,
    output logic        mdu_start,
    output logic [5:0]  mdu_alucode,
    output logic [31:0] mdu_op1,
    output logic [31:0] mdu_op2,
    input  logic [31:0] mdu_result,
    input  logic        mdu_done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expire;
    logic             accept;

    assign wd_expire  = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign accept     = (state == ST_IDLE) && req_valid && !flush;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mdu_start  = (state == ST_START);

`ifdef MULDIV_RESULT_REUSE_EN
    logic        reuse_vld;
    logic [5:0]  reuse_alucode;
    logic [31:0] reuse_op1;
    logic [31:0] reuse_op2;
    logic [31:0] reuse_result;
    logic        reuse_hit;

    assign reuse_hit = reuse_vld && (req_alucode == reuse_alucode)
                    && (req_op1 == reuse_op1) && (req_op2 == reuse_op2);

    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_vld     <= 1'b0;
            reuse_alucode <= '0;
            reuse_op1     <= '0;
            reuse_op2     <= '0;
            reuse_result  <= '0;
        end else begin
            if (state == ST_WAIT && mdu_done && !flush) begin
                reuse_vld     <= 1'b1;
                reuse_alucode <= mdu_alucode;
                reuse_op1     <= mdu_op1;
                reuse_op2     <= mdu_op2;
                reuse_result  <= mdu_result;
            end
            if (flush || ((state == ST_WAIT || state == ST_DRAIN) && !mdu_done && wd_expire))
                reuse_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            mdu_alucode <= '0;
            mdu_op1     <= '0;
            mdu_op2     <= '0;
            resp_data   <= '0;
            resp_rd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mdu_alucode <= req_alucode;
                        mdu_op1     <= req_op1;
                        mdu_op2     <= req_op2;
                        resp_rd     <= req_rd;
`ifdef MULDIV_RESULT_REUSE_EN
                        if (reuse_hit) begin
                            resp_data <= reuse_result;
                            state     <= ST_RESP;
                        end else begin
                            state     <= ST_START;
                        end
`else
                        state <= ST_START;
`endif
                    end
                end
                // done is not trusted at this edge; it may still be the previous op's flag
                ST_START: begin
                    wd_cnt <= '0;
                    state  <= flush ? ST_DRAIN : ST_WAIT;
                end
                // operands stay frozen here: the unit reads them live every stage
                ST_WAIT, ST_DRAIN: begin
                    if (mdu_done) begin
                        wd_cnt <= '0;
                        if (state == ST_WAIT && !flush) begin
                            resp_data <= mdu_result;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (flush)
                            state <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
